// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared widths, limits and encodings for the transmit path
// Purpose: default ADDR_W/DATA_W/BURST_W/MAX_PEND, transaction type encoding,
//          transmit FSM state type.
// Ports:   none (package).
package rtl_settings_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 128;
    localparam int DEF_BURST_W  = 11;
    localparam int DEF_MAX_PEND = 64;

    localparam logic TRANS_READ  = 1'b1;
    localparam logic TRANS_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        WRITE_S = 2'd1,
        READ_S  = 2'd2
    } trans_state_e;

endpackage

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - 32-bit LFSR write-data generator, x^32+x^22+x^2+x+1
// Purpose: pseudo-random word source; load takes priority over advance.
// Ports:   clk_i, rst_i (async active-low), load_i/seed_i (zero seed becomes 1),
//          en_i (advance one step), data_o (current LFSR state).
module lfsr_gen (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        en_i,
    output logic [31:0] data_o
);

    logic feedback;

    assign feedback = data_o[31] ^ data_o[21] ^ data_o[1] ^ data_o[0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
        end else if (load_i) begin
            // An all-zero state would lock up the LFSR.
            data_o <= (seed_i == 32'd0) ? 32'd1 : seed_i;
        end else if (en_i) begin
            data_o <= {data_o[30:0], feedback};
        end
    end

endmodule

// File: rtl/transmit_block.sv
// rtl/transmit_block.sv - command to Avalon-MM burst master with read credit tracking
// Purpose: accepts read/write commands, issues Avalon-MM bursts, tracks outstanding
//          read beats against MAX_PEND, reports issued reads to the compare block.
// Ports:   clk_i, rst_i (async active-low); trans_* command handshake and status;
//          burst_count_i, data_pattern_i from CSR; mem_* Avalon-MM master;
//          rd_cmd_* read-issue notification.
// Macro:   TRANS_LFSR_DATA_EN - write data from lfsr_gen instead of a fixed pattern.
module transmit_block
    import rtl_settings_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BURST_W  = DEF_BURST_W,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trans_valid_i,
    input  logic               trans_type_i,
    input  logic [ADDR_W-1:0]  trans_addr_i,
    input  logic [BURST_W-1:0] burst_count_i,
    input  logic [31:0]        data_pattern_i,
    output logic               trans_ready_o,
    output logic               trans_busy_o,
    output logic [ADDR_W-1:0]  mem_address_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [DATA_W-1:0]  mem_writedata_o,
    output logic [BURST_W-1:0] mem_burstcount_o,
    input  logic               mem_waitrequest_i,
    input  logic               mem_readdatavalid_i,
    output logic               rd_cmd_stb_o,
    output logic [ADDR_W-1:0]  rd_cmd_addr_o,
    output logic [BURST_W-1:0] rd_cmd_burst_o
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam int SUM_W  = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;
    localparam int REPL   = DATA_W / 32;

    trans_state_e       state;
    logic [PEND_W-1:0]  pending;
    logic [BURST_W-1:0] beats_left;
    logic [BURST_W-1:0] eff_burst;
    logic [SUM_W-1:0]   credit_sum;
    logic               credit_ok;
    logic               accept;
    logic               accept_wr;
    logic               wr_beat;
    logic               rd_issue;
    logic               rd_return;

    assign eff_burst  = (burst_count_i == '0) ? BURST_W'(1) : burst_count_i;
    assign credit_sum = SUM_W'(pending) + SUM_W'(eff_burst);
    assign credit_ok  = (trans_type_i == TRANS_WRITE) || (credit_sum <= SUM_W'(MAX_PEND));

    // Gated by rst_i so ready reads 0 while reset is held even though state is IDLE_S.
    assign trans_ready_o = rst_i && (state == IDLE_S) && credit_ok;
    assign accept        = trans_valid_i && trans_ready_o;
    assign accept_wr     = accept && (trans_type_i == TRANS_WRITE);

    assign wr_beat   = mem_write_o && !mem_waitrequest_i;
    assign rd_issue  = mem_read_o && !mem_waitrequest_i;
    // A readdatavalid with nothing outstanding is a stray and must not wrap the counter.
    assign rd_return = mem_readdatavalid_i && (pending != '0);

    assign rd_cmd_stb_o   = rd_issue;
    assign rd_cmd_addr_o  = mem_address_o;
    assign rd_cmd_burst_o = mem_burstcount_o;

    assign trans_busy_o = (state != IDLE_S) || (pending != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= IDLE_S;
            mem_address_o    <= '0;
            mem_burstcount_o <= '0;
            mem_read_o       <= 1'b0;
            mem_write_o      <= 1'b0;
            beats_left       <= '0;
        end else begin
            case (state)
                IDLE_S: begin
                    if (accept) begin
                        mem_address_o    <= trans_addr_i;
                        mem_burstcount_o <= eff_burst;
                        beats_left       <= eff_burst;
                        if (trans_type_i == TRANS_READ) begin
                            state      <= READ_S;
                            mem_read_o <= 1'b1;
                        end else begin
                            state       <= WRITE_S;
                            mem_write_o <= 1'b1;
                        end
                    end
                end
                WRITE_S: begin
                    if (!mem_waitrequest_i) begin
                        if (beats_left == BURST_W'(1)) begin
                            state       <= IDLE_S;
                            mem_write_o <= 1'b0;
                        end else begin
                            beats_left <= beats_left - BURST_W'(1);
                        end
                    end
                end
                READ_S: begin
                    if (!mem_waitrequest_i) begin
                        state      <= IDLE_S;
                        mem_read_o <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE_S;
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b0;
                end
            endcase
        end
    end

    // Credit admission keeps pending <= MAX_PEND, so the burst fits in PEND_W bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending <= '0;
        end else begin
            pending <= pending
                     + (rd_issue  ? PEND_W'(mem_burstcount_o) : PEND_W'(0))
                     - (rd_return ? PEND_W'(1)                : PEND_W'(0));
        end
    end

`ifdef TRANS_LFSR_DATA_EN
    logic [31:0] lfsr_word;

    lfsr_gen u_lfsr_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (accept_wr),
        .seed_i (data_pattern_i),
        .en_i   (wr_beat),
        .data_o (lfsr_word)
    );

    assign mem_writedata_o = {REPL{lfsr_word}};
`else
    logic [31:0] pattern_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pattern_q <= '0;
        end else if (accept_wr) begin
            pattern_q <= data_pattern_i;
        end
    end

    assign mem_writedata_o = {REPL{pattern_q}};
`endif

endmodule

// File: doc/transmit_block.md
TRANSMIT_BLOCK -- requirements
Module: transmit_block

Interface
REQ-001 Parameter ADDR_W, default 32, memory word address width (shared package constant).
REQ-002 Parameter DATA_W, default 128, memory data width.
REQ-003 Parameter BURST_W, default 11, burst count width.
REQ-004 Parameter MAX_PEND, default 64, maximum outstanding read beats.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, asynchronous assert, active-low.
REQ-007 trans_valid_i  in  1  command valid from control block.
REQ-008 trans_type_i  in  1  1 = read, 0 = write.
REQ-009 trans_addr_i  in  ADDR_W  command start address.
REQ-010 burst_count_i  in  BURST_W  beats per command, from CSR; 0 treated as 1.
REQ-011 data_pattern_i  in  32  write data pattern / seed, from CSR.
REQ-012 trans_ready_o  out  1  command accepted when valid && ready.
REQ-013 trans_busy_o  out  1  command in flight or read beats outstanding.
REQ-014 mem_address_o, mem_read_o, mem_write_o, mem_writedata_o[DATA_W], mem_burstcount_o[BURST_W]  out  Avalon-MM master command.
REQ-015 mem_waitrequest_i, mem_readdatavalid_i  in  1  Avalon-MM slave response.
REQ-016 rd_cmd_stb_o  out  1  one-cycle pulse when a read command is accepted by memory; rd_cmd_addr_o[ADDR_W] and rd_cmd_burst_o[BURST_W] valid with it (for compare block).

Function
REQ-017 FSM states IDLE_S, WRITE_S, READ_S; trans_ready_o = 1 only in IDLE_S with read credit available (REQ-022).
REQ-018 On accept: latch address, type, effective burst (max(burst_count_i,1)); next state WRITE_S or READ_S; mem_write_o/mem_read_o asserted the following cycle.
REQ-019 WRITE_S: mem_write_o held high; one beat consumed per cycle with !mem_waitrequest_i; address and burstcount constant for the whole burst; after last beat consumed return to IDLE_S next cycle.
REQ-020 Write data per beat: 32-bit pattern word replicated DATA_W/32 times; beat counter reloads per command.
REQ-021 READ_S: mem_read_o held high until !mem_waitrequest_i; that cycle: rd_cmd_stb_o pulse, pending += burst, return to IDLE_S.
REQ-022 Read credit: read command accepted only if pending + burst_count <= MAX_PEND; write commands need no credit.
REQ-023 pending decrements by 1 per mem_readdatavalid_i; simultaneous add and decrement apply both in the same cycle; pending never underflows (stray readdatavalid at 0 ignored).
REQ-024 trans_busy_o = (state != IDLE_S) || (pending != 0), registered-free combinational.
REQ-025 Back-to-back: with ready and valid held, new command accepted the cycle after returning to IDLE_S (2-cycle minimum per single-beat command).
REQ-026 trans_valid_i dropping while not ready has no effect; inputs sampled only at accept.

Reset
REQ-027 rst_i low: state IDLE_S, pending 0, all outputs 0 (trans_ready_o 0 during reset, 1 first cycle after release); reset mid-burst abandons command immediately.

Configuration
REQ-028 Macro TRANS_LFSR_DATA_EN defined: write data from 32-bit LFSR (x^32+x^22+x^2+x+1) seeded with data_pattern_i at each accepted write, advancing per consumed beat, zero seed replaced by 1.
REQ-029 TRANS_LFSR_DATA_EN undefined: fixed pattern per REQ-020, no LFSR logic synthesised.

Structure
REQ-030 ADDR_W, DATA_W, BURST_W, MAX_PEND defaults and the trans-type encoding (READ=1, WRITE=0) live in rtl_settings_pkg.
REQ-031 LFSR in sub-module lfsr_gen (seed load, enable, 32-bit out), instantiated only under TRANS_LFSR_DATA_EN.

Verification
REQ-032 Write, addr 0x100, burst 4, pattern 0xA5A5_0001, waitrequest low -> 4 beats addr 0x100, burstcount 4, data replicated pattern, busy drops cycle after beat 4.
REQ-033 Write burst 4 with waitrequest high on beats 2 and 3 for 3 cycles -> beat data/address stable while stalled, exactly 4 beats consumed.
REQ-034 Read burst 8 x 9 commands, MAX_PEND 64, no readdatavalid -> 8 accepted, ninth stalls ready low until 8 readdatavalid return.
REQ-035 readdatavalid coincident with read accept, pending 10, burst 4 -> pending 13.
REQ-036 burst_count_i 0 -> burstcount 1 issued; reset low mid-write-burst -> mem_write_o 0 immediately, busy 0.
REQ-037 TRANS_LFSR_DATA_EN, seed 0 -> first beat uses seed 1, subsequent beats match reference LFSR sequence.
